// File: rtl/latency_bucket_pkg.sv
// Shared constants, types and the latency-to-bin mapping for the latency histogram.
package latency_bucket_pkg;

  localparam int unsigned NUM_BUCKETS       = 32;
  localparam int unsigned LOG2_BUCKET_WIDTH = 0;
  localparam int unsigned CNT_W             = 32;
  localparam int unsigned IDX_W             = $clog2(NUM_BUCKETS);

  typedef logic [IDX_W-1:0] bucket_idx_t;
  typedef logic [CNT_W-1:0] cnt_t;
  // One extra bit so a saturated timer plus one still orders correctly.
  typedef logic [CNT_W:0]   lat_t;

  function automatic bucket_idx_t lat_to_idx(lat_t lat);
    lat_t bin;
    bin = lat >> LOG2_BUCKET_WIDTH;
    if (bin > lat_t'(NUM_BUCKETS - 1)) begin
      return bucket_idx_t'(NUM_BUCKETS - 1);
    end
    return bin[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/latency_bucket_store.sv
// Histogram counter array with increment port, registered read port and clear sweep.
// LATENCY_BUCKET_SATURATE_EN: counters saturate instead of wrapping.
module latency_bucket_store
  import latency_bucket_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        inc_valid,
  input  bucket_idx_t inc_idx,
  input  logic        clear,
  input  bucket_idx_t rd_id,
  output cnt_t        rd_value,
  output logic        clear_done
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StClear = 1'b1;

  logic [0:0]  state_q;
  bucket_idx_t sweep_idx_q;
  cnt_t        bucket_q [NUM_BUCKETS];
  cnt_t        rd_value_q;
  logic        done_q;
  cnt_t        inc_next;
  logic        sweep_last;

  assign sweep_last = (sweep_idx_q == bucket_idx_t'(NUM_BUCKETS - 1));

  always_comb begin
`ifdef LATENCY_BUCKET_SATURATE_EN
    inc_next = (bucket_q[inc_idx] == '1) ? bucket_q[inc_idx] : bucket_q[inc_idx] + cnt_t'(1);
`else
    inc_next = bucket_q[inc_idx] + cnt_t'(1);
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      sweep_idx_q <= '0;
      done_q      <= 1'b0;
    end else begin
      // Done only when the final bucket is cleared without a restart in the same cycle.
      done_q <= !clear && (state_q == StClear) && sweep_last;
      if (clear) begin
        state_q     <= StClear;
        sweep_idx_q <= '0;
      end else if (state_q == StClear) begin
        sweep_idx_q <= sweep_idx_q + bucket_idx_t'(1);
        if (sweep_last) state_q <= StIdle;
      end
    end
  end

  // Increments arriving while the sweep runs are dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BUCKETS; i++) bucket_q[i] <= '0;
    end else if (state_q == StClear) begin
      bucket_q[sweep_idx_q] <= '0;
    end else if (inc_valid) begin
      bucket_q[inc_idx] <= inc_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_value_q <= '0;
    end else begin
      rd_value_q <= (32'(rd_id) < NUM_BUCKETS) ? bucket_q[rd_id] : '0;
    end
  end

  assign rd_value   = rd_value_q;
  assign clear_done = done_q;

endmodule

// File: rtl/latency_bucket.sv
// Passive start-to-end latency monitor feeding a histogram of hit counters.
// LATENCY_BUCKET_SATURATE_EN: bucket counters saturate instead of wrapping.
module latency_bucket
  import latency_bucket_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             io_enable,
  input  logic             io_start,
  input  logic             io_end,
  input  logic [IDX_W-1:0] io_bucketRdId,
  output logic [CNT_W-1:0] io_bucketValue,
  input  logic             io_resetBucket,
  output logic             io_resetDone
);

  logic        busy_q;
  cnt_t        timer_q;
  logic        end_ok;
  bucket_idx_t end_idx;

  assign end_ok  = io_end && io_enable && busy_q;
  // Timer holds cycles since start minus one, so latency is timer + 1.
  assign end_idx = lat_to_idx(lat_t'(timer_q) + lat_t'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q  <= 1'b0;
      timer_q <= '0;
    end else if (!io_enable) begin
      busy_q <= 1'b0;
    end else if (io_start) begin
      busy_q  <= 1'b1;
      timer_q <= '0;
    end else if (end_ok) begin
      busy_q <= 1'b0;
    end else if (busy_q && (timer_q != '1)) begin
      timer_q <= timer_q + cnt_t'(1);
    end
  end

  latency_bucket_store u_store (
    .clock      (clock),
    .reset      (reset),
    .inc_valid  (end_ok),
    .inc_idx    (end_idx),
    .clear      (io_resetBucket),
    .rd_id      (io_bucketRdId),
    .rd_value   (io_bucketValue),
    .clear_done (io_resetDone)
  );

endmodule

// File: tb/tb_latency_bucket.sv
// Self-checking bench for latency_bucket: directed plan plus random traffic vs. a timestamp model.
module tb_latency_bucket;
  import latency_bucket_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_enable = 1'b0;
  logic        io_start = 1'b0;
  logic        io_end = 1'b0;
  logic [4:0]  io_bucketRdId = '0;
  logic [31:0] io_bucketValue;
  logic        io_resetBucket = 1'b0;
  logic        io_resetDone;

  int          n_tests = 0;
  int          n_fail  = 0;
  longint      mb [32];
  bit          m_busy = 1'b0;
  longint      t_start = 0;

  always #5 clock = ~clock;

  latency_bucket dut (
    .clock          (clock),
    .reset          (reset),
    .io_enable      (io_enable),
    .io_start       (io_start),
    .io_end         (io_end),
    .io_bucketRdId  (io_bucketRdId),
    .io_bucketValue (io_bucketValue),
    .io_resetBucket (io_resetBucket),
    .io_resetDone   (io_resetDone)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mb[i] = 0;
    m_busy = 1'b0;
  endtask

  // Drive one cycle; the model bins by edge-timestamp difference.
  task automatic step(input bit en, input bit st, input bit ed);
    longint lat;
    longint bin;
    @(negedge clock);
    io_enable = en;
    io_start  = st;
    io_end    = ed;
    @(posedge clock);
    if (!en) begin
      m_busy = 1'b0;
    end else begin
      if (ed && m_busy) begin
        lat = (longint'($time) - t_start) / 10;
        bin = lat >> LOG2_BUCKET_WIDTH;
        if (bin > 31) bin = 31;
        mb[bin] = (mb[bin] + 1) & 64'hFFFF_FFFF;
        m_busy = 1'b0;
      end
      if (st) begin
        m_busy  = 1'b1;
        t_start = longint'($time);
      end
    end
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) step(en, 1'b0, 1'b0);
  endtask

  task automatic read_check(input int id, input longint exp, input string tag);
    @(negedge clock);
    io_start      = 1'b0;
    io_end        = 1'b0;
    io_bucketRdId = 5'(id);
    @(posedge clock);
    #1;
    check(tag, io_bucketValue, exp);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 32; i++) read_check(i, mb[i], tag);
  endtask

  task automatic sweep_check();
    int first;
    int highs;
    first = 0;
    highs = 0;
    @(negedge clock);
    io_start       = 1'b0;
    io_end         = 1'b0;
    io_resetBucket = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (k == 1) io_resetBucket = 1'b0;
      if (io_resetDone) begin
        highs++;
        if (first == 0) first = k;
      end
    end
    check("done_at", first, 33);
    check("done_width", highs, 1);
    for (int i = 0; i < 32; i++) mb[i] = 0;
  endtask

  initial begin
    int prev;
    int highs;
    repeat (3) @(posedge clock);
    #1;
    check("rst_value", io_bucketValue, 0);
    check("rst_done", io_resetDone, 0);
    @(negedge clock);
    reset = 1'b1;
    model_clear();

    // Start then end four cycles later, then a stray end and an 11-cycle measurement.
    idle(5, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    read_check(4, 1, "plan_b4");
    read_all("plan1_all");
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    idle(10, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    read_check(11, 1, "plan_b11");
    read_check(4, 1, "plan_b4_kept");

    // Dwell sweep with enable low, checking the one-cycle read latency.
    @(negedge clock);
    io_enable = 1'b0;
    read_check(31, mb[31], "rd_pre");
    prev = 31;
    for (int id = 0; id < 32; id++) begin
      @(negedge clock);
      io_bucketRdId = 5'(id);
      #1;
      check("rd_hold", io_bucketValue, mb[prev]);
      @(posedge clock);
      #1;
      check("rd_val", io_bucketValue, mb[id]);
      repeat (4) @(posedge clock);
      prev = id;
    end

    sweep_check();
    read_all("after_clear");

    step(1'b1, 1'b1, 1'b0);
    idle(39, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    read_check(31, 1, "clamp_b31");

    step(1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    idle(4, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    read_check(3, 1, "b2b_b3");
    read_check(5, 1, "b2b_b5");

    // Disabling mid-measurement abandons it.
    step(1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    read_all("abandon_all");

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 95, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 10);
    end
    read_all("rand_all");

    // Reset in the middle of a sweep: no done pulse, everything cleared.
    @(negedge clock);
    io_resetBucket = 1'b1;
    @(posedge clock);
    #1;
    io_resetBucket = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("abort_value", io_bucketValue, 0);
    #20;
    @(negedge clock);
    reset = 1'b1;
    model_clear();
    highs = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (io_resetDone) highs++;
    end
    check("abort_no_done", highs, 0);
    read_all("abort_all");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
